// File: rtl/array_pop_engine.sv
// Per-array LIFO heap store: push appends, pop returns the last element through a
// response handshake. Optional index checking is enabled by ARRAY_POP_BOUNDS_CHECK_EN.
module array_pop_engine #(
   parameter int MemoryElementWidth = 12,
   parameter int NArea              = 8,
   parameter int NArrays            = 4,
   localparam int AW                = (NArrays > 1) ? $clog2(NArrays) : 1
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          push_valid,
   input  logic [AW-1:0]                 push_array,
   input  logic [MemoryElementWidth-1:0] push_data,
   output logic                          push_ready,
   input  logic                          pop_valid,
   input  logic [AW-1:0]                 pop_array,
   output logic                          pop_ready,
   output logic                          rsp_valid,
   output logic [MemoryElementWidth-1:0] rsp_data,
   output logic                          rsp_empty,
   input  logic                          rsp_ready,
   input  logic [AW-1:0]                 size_array,
   output logic [MemoryElementWidth-1:0] size,
   output logic                          push_overflow
);

   localparam int SW    = $clog2(NArea + 1);
   localparam int Depth = NArrays * NArea;
   localparam int HAW   = (Depth > 1) ? $clog2(Depth) : 1;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]                    state_q, state_d;
   logic [MemoryElementWidth-1:0] rsp_data_q, rsp_data_d;
   logic                          rsp_empty_q, rsp_empty_d;
   logic                          overflow_q, overflow_d;
   logic [SW-1:0]                 size_q [NArrays];
   logic [MemoryElementWidth-1:0] heap_q [Depth];
   logic [MemoryElementWidth-1:0] rd_data_q;

   logic                          push_fire, pop_fire;
   logic                          push_in_range, pop_in_range, size_in_range;
   logic [SW-1:0]                 push_size, pop_size;
   logic                          push_full, pop_empty, pop_empty_eff;
   logic [HAW-1:0]                wr_addr, rd_addr;
   logic [NArrays-1:0]            inc_vec, dec_vec;

`ifdef ARRAY_POP_BOUNDS_CHECK_EN
   assign push_in_range = (int'(push_array) < NArrays);
   assign pop_in_range  = (int'(pop_array) < NArrays);
   assign size_in_range = (int'(size_array) < NArrays);
`else
   assign push_in_range = 1'b1;
   assign pop_in_range  = 1'b1;
   assign size_in_range = 1'b1;
`endif

   assign push_ready = (state_q == ST_IDLE);
   assign pop_ready  = (state_q == ST_IDLE) && !push_valid;
   assign push_fire  = push_valid && push_ready;
   assign pop_fire   = pop_valid && pop_ready;

   assign push_size     = push_in_range ? size_q[push_array] : '0;
   assign pop_size      = pop_in_range ? size_q[pop_array] : '0;
   assign push_full     = (push_size == SW'(NArea));
   assign pop_empty     = (pop_size == '0);
   assign pop_empty_eff = pop_empty || !pop_in_range;

   assign wr_addr = HAW'(int'(push_array) * NArea + int'(push_size));
   assign rd_addr = HAW'(int'(pop_array) * NArea + int'(pop_size) - 1);

   // Heap is plain block RAM: no reset, registered read consumed in READ.
   always_ff @(posedge clock) begin
      if (push_fire && push_in_range && !push_full) begin
         heap_q[wr_addr] <= push_data;
      end
      if (pop_fire && !pop_empty_eff) begin
         rd_data_q <= heap_q[rd_addr];
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NArrays; gi++) begin : g_size_ctl
         assign inc_vec[gi] = push_fire && push_in_range && !push_full &&
                              (push_array == AW'(gi));
         assign dec_vec[gi] = pop_fire && pop_in_range && !pop_empty &&
                              (pop_array == AW'(gi));
      end
   endgenerate

   // Push and pop never fire together, so inc and dec are mutually exclusive.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NArrays; i++) size_q[i] <= '0;
      end else begin
         for (int i = 0; i < NArrays; i++) begin
            if (inc_vec[i])      size_q[i] <= size_q[i] + 1'b1;
            else if (dec_vec[i]) size_q[i] <= size_q[i] - 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rsp_data_d  = rsp_data_q;
      rsp_empty_d = rsp_empty_q;
      overflow_d  = overflow_q;
      if (push_fire && (!push_in_range || push_full)) overflow_d = 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (pop_fire) begin
               if (pop_empty_eff) begin
                  rsp_empty_d = 1'b1;
                  rsp_data_d  = '0;
                  state_d     = ST_RESP;
               end else begin
                  state_d = ST_READ;
               end
            end
         end
         ST_READ: begin
            rsp_data_d  = rd_data_q;
            rsp_empty_d = 1'b0;
            state_d     = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         rsp_data_q  <= '0;
         rsp_empty_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         rsp_data_q  <= rsp_data_d;
         rsp_empty_q <= rsp_empty_d;
         overflow_q  <= overflow_d;
      end
   end

   assign rsp_valid     = (state_q == ST_RESP);
   assign rsp_data      = rsp_data_q;
   assign rsp_empty     = rsp_empty_q;
   assign push_overflow = overflow_q;
   assign size          = size_in_range ? MemoryElementWidth'(size_q[size_array]) : '0;

endmodule

// File: tb/tb_array_pop_engine.sv
// Directed bench for array_pop_engine: a table of push/pop transactions plus
// hand-written sequences for stalls, push/pop collisions, reset and bounds checks.
module tb_array_pop_engine;

`ifdef ARRAY_POP_BOUNDS_CHECK_EN
   localparam int NARR = 3;
`else
   localparam int NARR = 4;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        push_valid = 1'b0;
   logic [1:0]  push_array = '0;
   logic [11:0] push_data = '0;
   logic        push_ready;
   logic        pop_valid = 1'b0;
   logic [1:0]  pop_array = '0;
   logic        pop_ready;
   logic        rsp_valid;
   logic [11:0] rsp_data;
   logic        rsp_empty;
   logic        rsp_ready = 1'b1;
   logic [1:0]  size_array = '0;
   logic [11:0] size;
   logic        push_overflow;

   int checks = 0;
   int errors = 0;

   array_pop_engine #(.MemoryElementWidth(12), .NArea(8), .NArrays(NARR)) dut (
      .clock(clock), .reset_n(reset_n),
      .push_valid(push_valid), .push_array(push_array), .push_data(push_data),
      .push_ready(push_ready),
      .pop_valid(pop_valid), .pop_array(pop_array), .pop_ready(pop_ready),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_empty(rsp_empty),
      .rsp_ready(rsp_ready),
      .size_array(size_array), .size(size), .push_overflow(push_overflow)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          is_pop;
      logic [1:0]  arr;
      logic [11:0] data;
      logic [11:0] exp_data;
      bit          exp_empty;
      int          exp_size;
      bit          exp_ovf;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_push(input logic [1:0] a, input logic [11:0] d, input int es, input bit eo);
      vecs.push_back('{is_pop: 1'b0, arr: a, data: d, exp_data: 12'h0, exp_empty: 1'b0,
                       exp_size: es, exp_ovf: eo});
   endtask

   task automatic add_pop(input logic [1:0] a, input logic [11:0] ed, input bit ee, input int es, input bit eo);
      vecs.push_back('{is_pop: 1'b1, arr: a, data: 12'h0, exp_data: ed, exp_empty: ee,
                       exp_size: es, exp_ovf: eo});
   endtask

   task automatic do_push(input logic [1:0] a, input logic [11:0] d, input string tag);
      @(negedge clock);
      push_valid = 1'b1; push_array = a; push_data = d;
      #1 chk({tag, " push_ready"}, push_ready, 1);
      @(negedge clock);
      push_valid = 1'b0;
   endtask

   // Pop with rsp_ready held high; latency counted in negedges after acceptance.
   task automatic do_pop(input logic [1:0] a, input logic [11:0] ed, input bit ee, input string tag);
      int cnt;
      @(negedge clock);
      pop_valid = 1'b1; pop_array = a; rsp_ready = 1'b1;
      #1 chk({tag, " pop_ready"}, pop_ready, 1);
      @(negedge clock);
      pop_valid = 1'b0;
      cnt = 1;
      while (!rsp_valid && cnt < 8) begin
         @(negedge clock);
         cnt++;
      end
      chk({tag, " latency"}, cnt, ee ? 1 : 2);
      chk({tag, " rsp_data"}, rsp_data, ed);
      chk({tag, " rsp_empty"}, rsp_empty, ee);
      @(negedge clock);
      chk({tag, " rsp_valid drop"}, rsp_valid, 0);
   endtask

   task automatic chk_all_sizes_zero(input string tag);
      for (int a = 0; a < NARR; a++) begin
         size_array = a[1:0];
         #1 chk($sformatf("%s size(%0d)", tag, a), size, 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int cnt;

      add_push(2'd0, 12'd1, 1, 1'b0);
      add_push(2'd0, 12'd2, 2, 1'b0);
      add_pop (2'd0, 12'd2, 1'b0, 1, 1'b0);
      add_pop (2'd0, 12'd1, 1'b0, 0, 1'b0);
      add_pop (2'd1, 12'd0, 1'b1, 0, 1'b0);
      for (int k = 0; k < 9; k++) begin
         add_push(2'd2, 12'(10 + k), (k < 8) ? k + 1 : 8, k == 8);
      end
      add_pop (2'd2, 12'd17, 1'b0, 7, 1'b1);
      add_push(2'd1, 12'h5A5, 1, 1'b1);
      add_push(2'd1, 12'hFFF, 2, 1'b1);
      add_pop (2'd1, 12'hFFF, 1'b0, 1, 1'b1);
      add_pop (2'd1, 12'h5A5, 1'b0, 0, 1'b1);
      add_pop (2'd1, 12'h000, 1'b1, 0, 1'b1);

      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      #1;
      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset rsp_data", rsp_data, 0);
      chk("reset rsp_empty", rsp_empty, 0);
      chk("reset push_overflow", push_overflow, 0);
      chk("reset push_ready", push_ready, 1);
      chk("reset pop_ready", pop_ready, 1);
      chk_all_sizes_zero("reset");

      foreach (vecs[i]) begin
         if (vecs[i].is_pop) begin
            do_pop(vecs[i].arr, vecs[i].exp_data, vecs[i].exp_empty, $sformatf("vec%0d", i));
         end else begin
            do_push(vecs[i].arr, vecs[i].data, $sformatf("vec%0d", i));
         end
         size_array = vecs[i].arr;
         #1;
         chk($sformatf("vec%0d size", i), size, vecs[i].exp_size);
         chk($sformatf("vec%0d overflow", i), push_overflow, vecs[i].exp_ovf);
         $display("vec%0d %s arr=%0d data=%0h rsp=%0h empty=%0b size=%0d ovf=%0b",
                  i, vecs[i].is_pop ? "pop " : "push", vecs[i].arr, vecs[i].data,
                  rsp_data, rsp_empty, size, push_overflow);
      end

      // Response stall with rsp_ready low.
      do_push(2'd1, 12'h123, "stall");
      @(negedge clock);
      pop_valid = 1'b1; pop_array = 2'd1; rsp_ready = 1'b0;
      @(negedge clock);
      pop_valid = 1'b0;
      cnt = 1;
      while (!rsp_valid && cnt < 8) begin
         @(negedge clock);
         cnt++;
      end
      chk("stall latency", cnt, 2);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("stall rsp_valid c%0d", k), rsp_valid, 1);
         chk($sformatf("stall rsp_data c%0d", k), rsp_data, 12'h123);
         chk($sformatf("stall push_ready c%0d", k), push_ready, 0);
         chk($sformatf("stall pop_ready c%0d", k), pop_ready, 0);
         @(negedge clock);
      end
      rsp_ready = 1'b1;
      @(negedge clock);
      chk("stall release rsp_valid", rsp_valid, 0);
      chk("stall release push_ready", push_ready, 1);
      $display("stall pop arr=1 data=%0h held 5 cycles", 12'h123);

      // Push and pop requested together: push wins, pop follows.
      @(negedge clock);
      push_valid = 1'b1; push_array = 2'd0; push_data = 12'h777;
      pop_valid = 1'b1; pop_array = 2'd0; size_array = 2'd0;
      #1;
      chk("collide pop_ready", pop_ready, 0);
      chk("collide push_ready", push_ready, 1);
      @(negedge clock);
      push_valid = 1'b0;
      #1;
      chk("collide pop_ready next", pop_ready, 1);
      chk("collide size after push", size, 1);
      @(negedge clock);
      pop_valid = 1'b0;
      cnt = 1;
      while (!rsp_valid && cnt < 8) begin
         @(negedge clock);
         cnt++;
      end
      chk("collide latency", cnt, 2);
      chk("collide rsp_data", rsp_data, 12'h777);
      chk("collide rsp_empty", rsp_empty, 0);
      @(negedge clock);
      chk("collide size after pop", size, 0);
      $display("collide push+pop arr=0 data=%0h", rsp_data);

      // Asynchronous reset while the pop is in READ.
      do_push(2'd1, 12'h042, "rst");
      do_push(2'd2, 12'h043, "rst");
      @(negedge clock);
      pop_valid = 1'b1; pop_array = 2'd1;
      @(negedge clock);
      pop_valid = 1'b0;
      #1 reset_n = 1'b0;
      #1;
      chk("rst rsp_valid", rsp_valid, 0);
      chk("rst rsp_data", rsp_data, 0);
      chk("rst push_overflow", push_overflow, 0);
      chk("rst push_ready", push_ready, 1);
      chk_all_sizes_zero("rst");
      @(negedge clock);
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         chk($sformatf("rst lost rsp c%0d", k), rsp_valid, 0);
      end
      $display("reset during READ: response dropped, sizes cleared");

`ifdef ARRAY_POP_BOUNDS_CHECK_EN
      do_pop(2'd3, 12'h000, 1'b1, "oob");
      do_push(2'd3, 12'h111, "oob");
      chk("oob push_overflow", push_overflow, 1);
      size_array = 2'd3;
      #1 chk("oob size", size, 0);
      chk_all_sizes_zero("oob");
      $display("bounds: pop/push on array 3 handled as out of range");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
